// File: rtl/aes_block_feeder.sv
`default_nettype none
// ============================================================================
// Module   : aes_block_feeder
// Purpose  : Upstream stage of the AES encipher core. Packs four 32-bit words
//            from a valid/ready stream into a 128-bit block, launches it on
//            the core load bus with a one-cycle enable pulse, times the core's
//            fixed round latency and pulses done when core_out is valid.
//            One packed block is buffered so the next block can be collected
//            while the core is running.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            s_valid/s_ready   - input word handshake
//            s_data[31:0]      - input word; first word lands in [127:96]
//            core_load[127:0]  - block presented to the core
//            core_enable       - one-cycle start pulse to the core
//            core_out[127:0]   - ciphertext from the core
//            done              - one-cycle pulse, core_out valid
//            busy              - core running (LAUNCH or RUN)
//            blk_count         - completed-block counter, wraps
//            iv[127:0], iv_load- chaining IV load (CBC_EN builds only)
// Options  : define CBC_EN to add the CBC chain register.
// Revision : 1.0 - initial release
// ============================================================================
module aes_block_feeder #(
  parameter int LATENCY = 12,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  output logic [127:0]     core_load,
  output logic             core_enable,
  input  logic [127:0]     core_out,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] blk_count,
  input  logic [127:0]     iv,
  input  logic             iv_load
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  // LATENCY is at most 31, so five bits hold every counter value.
  localparam logic [4:0] C_LAST_CNT = 5'(LATENCY - 1);

  state_t             state_q, state_d;
  logic [127:0]       pack_q, pack_d;
  logic [1:0]         idx_q, idx_d;
  logic               pack_full_q, pack_full_d;
  logic [127:0]       core_load_q, core_load_d;
  logic               core_enable_q, core_enable_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   blk_count_q, blk_count_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [127:0]       launch_blk;
  logic               accept;

`ifdef CBC_EN
  logic [127:0]       chain_q, chain_d;

  assign launch_blk = pack_q ^ chain_q;

  // iv_load takes priority over capturing the finished ciphertext.
  always_comb begin
    chain_d = chain_q;
    if (done_q)  chain_d = core_out;
    if (iv_load) chain_d = iv;
  end

  always_ff @(posedge clk) begin
    if (reset) chain_q <= '0;
    else       chain_q <= chain_d;
  end
`else
  logic unused_cbc;

  assign launch_blk = pack_q;
  assign unused_cbc = ^{core_out, iv, iv_load};
`endif

  assign s_ready     = !pack_full_q;
  assign accept      = s_valid && !pack_full_q;
  assign busy        = (state_q != ST_IDLE);
  assign core_load   = core_load_q;
  assign core_enable = core_enable_q;
  assign done        = done_q;
  assign blk_count   = blk_count_q;

  always_comb begin
    state_d       = state_q;
    pack_d        = pack_q;
    idx_d         = idx_q;
    pack_full_d   = pack_full_q;
    core_load_d   = core_load_q;
    core_enable_d = 1'b0;
    done_d        = 1'b0;
    blk_count_d   = blk_count_q;
    cnt_d         = cnt_q;

    // Word packer: runs in every state while the buffer slot is free.
    if (accept) begin
      case (idx_q)
        2'd0:    pack_d[127:96] = s_data;
        2'd1:    pack_d[95:64]  = s_data;
        2'd2:    pack_d[63:32]  = s_data;
        default: pack_d[31:0]   = s_data;
      endcase
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) pack_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        // accept is necessarily low here when pack_full_q is set.
        if (pack_full_q) begin
          core_load_d   = launch_blk;
          core_enable_d = 1'b1;
          pack_full_d   = 1'b0;
          state_d       = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        cnt_d   = 5'd1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == C_LAST_CNT) begin
          done_d      = 1'b1;
          blk_count_d = blk_count_q + CNT_W'(1);
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pack_q        <= '0;
      idx_q         <= '0;
      pack_full_q   <= 1'b0;
      core_load_q   <= '0;
      core_enable_q <= 1'b0;
      done_q        <= 1'b0;
      blk_count_q   <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pack_q        <= pack_d;
      idx_q         <= idx_d;
      pack_full_q   <= pack_full_d;
      core_load_q   <= core_load_d;
      core_enable_q <= core_enable_d;
      done_q        <= done_d;
      blk_count_q   <= blk_count_d;
      cnt_q         <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_block_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_block_feeder
// Purpose  : Self-checking bench for aes_block_feeder. A cycle-indexed model
//            (word queue plus launch timestamp) predicts every output; a
//            compare process checks them each cycle, and directed scenarios
//            add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_block_feeder;

  localparam int LAT   = 12;
  localparam int CNT_W = 3;

  logic             clk;
  logic             reset;
  logic             s_valid;
  logic             s_ready;
  logic [31:0]      s_data;
  logic [127:0]     core_load;
  logic             core_enable;
  logic [127:0]     core_out;
  logic             done;
  logic             busy;
  logic [CNT_W-1:0] blk_count;
  logic [127:0]     iv;
  logic             iv_load;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  aes_block_feeder #(.LATENCY(LAT), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .core_load   (core_load),
    .core_enable (core_enable),
    .core_out    (core_out),
    .done        (done),
    .busy        (busy),
    .blk_count   (blk_count),
    .iv          (iv),
    .iv_load     (iv_load)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation timeout");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A block launched with enable in cycle m_en is busy for cycles
  // [m_en, m_en+LAT) and reports done in cycle m_en+LAT.
  int               m_cyc = 0;
  int               m_en  = -1000;
  logic [31:0]      m_words[$];
  bit               m_full = 0;
  logic [127:0]     m_blk = '0;
  logic [127:0]     m_load = '0;
  logic [127:0]     m_chain = '0;
  logic [CNT_W-1:0] m_count = '0;

  always @(posedge clk) begin : model
    int c;
    bit busy_now;
    bit done_now;
    c = m_cyc;
    if (reset) begin
      m_words.delete();
      m_full  = 0;
      m_blk   = '0;
      m_load  = '0;
      m_en    = -1000;
      m_count = '0;
      m_chain = '0;
    end else begin
      busy_now = (m_en <= c) && (c < m_en + LAT);
      done_now = (c == m_en + LAT);
      if (c + 1 == m_en + LAT) m_count = m_count + 1'b1;
      if (!busy_now && m_full) begin
`ifdef CBC_EN
        m_load = m_blk ^ m_chain;
`else
        m_load = m_blk;
`endif
        m_full = 0;
        m_en   = c + 1;
      end else if (s_valid && !m_full) begin
        m_words.push_back(s_data);
        if (m_words.size() == 4) begin
          m_blk  = {m_words[0], m_words[1], m_words[2], m_words[3]};
          m_full = 1;
          m_words.delete();
        end
      end
`ifdef CBC_EN
      if (iv_load)       m_chain = iv;
      else if (done_now) m_chain = core_out;
`endif
    end
    m_cyc = m_cyc + 1;
  end

  // Enable / done history in model cycle numbers, for latency checks.
  int en_hist[$];
  int done_hist[$];

  always @(negedge clk) begin : compare
    if (chk_on) begin
      chk("s_ready",     128'(s_ready),     128'(!m_full));
      chk("core_enable", 128'(core_enable), 128'(m_cyc == m_en));
      chk("done",        128'(done),        128'(m_cyc == m_en + LAT));
      chk("busy",        128'(busy),        128'((m_en <= m_cyc) && (m_cyc < m_en + LAT)));
      chk("core_load",   core_load,         m_load);
      chk("blk_count",   128'(blk_count),   128'(m_count));
      if (core_enable) en_hist.push_back(m_cyc);
      if (done)        done_hist.push_back(m_cyc);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input logic [31:0] w, input bit gap);
    bit got;
    got     = 0;
    s_valid = 1'b1;
    s_data  = w;
    for (int k = 0; k < 100; k++) begin
      if (s_ready) begin
        got = 1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    if (!got) chk("push_timeout", 128'(0), 128'(1));
    if (gap) begin
      s_data = $urandom;
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input int n);
    bit got;
    got = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (done_hist.size() >= n) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("done_timeout", 128'(done_hist.size()), 128'(n));
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    en_hist.delete();
    done_hist.delete();
  endtask

  // ---------------- directed + random scenarios ----------------
  initial begin
    bit got;
    reset    = 1'b1;
    s_valid  = 1'b0;
    s_data   = '0;
    core_out = '0;
    iv       = '0;
    iv_load  = 1'b0;
    repeat (3) @(negedge clk);
    chk_on = 1;
    chk("rst_s_ready",   128'(s_ready),   128'(1));
    chk("rst_busy",      128'(busy),      128'(0));
    chk("rst_core_load", core_load,       128'(0));
    chk("rst_blk_count", 128'(blk_count), 128'(0));
    reset = 1'b0;

    // Single block, contiguous words.
    push(32'h00112233, 0);
    push(32'h44556677, 0);
    push(32'h8899AABB, 0);
    push(32'hCCDDEEFF, 0);
    chk("full_s_ready", 128'(s_ready), 128'(0));
    wait_done(1);
    chk("t1_core_load", core_load, 128'h00112233445566778899AABBCCDDEEFF);
    chk("t1_enables", 128'(en_hist.size()), 128'(1));
    if (en_hist.size() == 1 && done_hist.size() == 1)
      chk("t1_latency", 128'(done_hist[0] - en_hist[0]), 128'(12));
    chk("t1_blk_count", 128'(blk_count), 128'(1));

    // Eight words back-to-back.
    apply_reset();
    for (int i = 0; i < 8; i++) push(32'h10000000 * (i + 1) + i, 0);
    wait_done(2);
    if (en_hist.size() >= 2)
      chk("t2_period", 128'(en_hist[1] - en_hist[0]), 128'(13));
    chk("t2_core_load", core_load, 128'h50000004600000057000000680000007);
    chk("t2_blk_count", 128'(blk_count), 128'(2));

    // s_valid toggling: same block as the contiguous case.
    apply_reset();
    push(32'h00112233, 1);
    push(32'h44556677, 1);
    push(32'h8899AABB, 1);
    push(32'hCCDDEEFF, 1);
    wait_done(1);
    chk("t3_core_load", core_load, 128'h00112233445566778899AABBCCDDEEFF);

    // Reset in RUN at counter 5 with two words pending.
    apply_reset();
    push(32'h00112233, 0);
    push(32'h44556677, 0);
    push(32'h8899AABB, 0);
    push(32'hCCDDEEFF, 0);
    got = 0;
    for (int k = 0; k < 20; k++) begin
      if (core_enable) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    if (!got) chk("t4_enable_timeout", 128'(0), 128'(1));
    push(32'hDEADBEEF, 0);
    push(32'hCAFEF00D, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t4_core_load",   core_load,         128'(0));
    chk("t4_busy",        128'(busy),        128'(0));
    chk("t4_done",        128'(done),        128'(0));
    chk("t4_core_enable", 128'(core_enable), 128'(0));
    chk("t4_blk_count",   128'(blk_count),   128'(0));
    reset = 1'b0;
    repeat (15) @(negedge clk);
    chk("t4_no_done", 128'(done_hist.size()), 128'(0));
    push(32'h01234567, 0);
    push(32'h89ABCDEF, 0);
    push(32'hFEDCBA98, 0);
    push(32'h76543210, 0);
    wait_done(1);
    chk("t4_fresh_block", core_load, 128'h0123456789ABCDEFFEDCBA9876543210);

`ifdef CBC_EN
    // IV then two zero blocks; the second sees the modelled ciphertext.
    apply_reset();
    core_out = {16{8'hA5}};
    iv       = 128'h000102030405060708090A0B0C0D0E0F;
    iv_load  = 1'b1;
    @(negedge clk);
    iv_load = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h0, 0);
    wait_done(1);
    chk("cbc_iv_block", core_load, 128'h000102030405060708090A0B0C0D0E0F);
    for (int i = 0; i < 4; i++) push(32'h0, 0);
    wait_done(2);
    chk("cbc_chain_block", core_load, {16{8'hA5}});
    // iv_load on the done cycle beats the ciphertext capture.
    iv = 128'hFFEEDDCCBBAA99887766554433221100;
    for (int i = 0; i < 4; i++) push(32'h0, 0);
    got = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("cbc_done_timeout", 128'(0), 128'(1));
    iv_load = 1'b1;
    @(negedge clk);
    iv_load = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h0, 0);
    wait_done(4);
    chk("cbc_iv_wins", core_load, 128'hFFEEDDCCBBAA99887766554433221100);
`endif

    // Randomized traffic, checked cycle by cycle against the model.
    apply_reset();
    for (int i = 0; i < 500; i++) begin
      s_valid  = 1'($urandom_range(0, 1));
      s_data   = $urandom;
      core_out = {$urandom, $urandom, $urandom, $urandom};
`ifdef CBC_EN
      iv      = {$urandom, $urandom, $urandom, $urandom};
      iv_load = ($urandom_range(0, 15) == 0);
`endif
      @(negedge clk);
    end
    s_valid = 1'b0;
    iv_load = 1'b0;
    repeat (30) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_block_feeder.md
Name: aes_block_feeder

Overview:
- Upstream stage of the AES encipher core. Accepts a 32-bit word stream on a valid/ready handshake and packs four words into one 128-bit block.
- Drives the core's load bus and issues a one-cycle enable pulse per block.
- Times the core's fixed round latency and signals completion.
- Buffers one packed block, so the next block can be collected while the core is busy.

Parameters:
- LATENCY, 12, clock cycles from the enable pulse until core_out holds that block's ciphertext (Nk=4 core: Nr+2); legal range 2..31.
- CNT_W, 16, width of the completed-block counter.

Ports:
- clk  input  1  system clock, all logic on the rising edge
- reset  input  1  synchronous, active-high reset
- s_valid  input  1  input word valid
- s_ready  output  1  feeder can accept a word this cycle
- s_data  input  32  input word; the first word of a block lands in bits [127:96]
- core_load  output  128  block presented to the encipher core's load input
- core_enable  output  1  one-cycle start pulse to the core
- core_out  input  128  ciphertext from the core
- done  output  1  one-cycle pulse: core_out is valid for the launched block
- busy  output  1  core is running (LAUNCH or RUN state)
- blk_count  output  CNT_W  number of completed blocks, wraps modulo 2^CNT_W
- iv  input  128  chaining IV (used only with CBC_EN)
- iv_load  input  1  load iv into the chain register (used only with CBC_EN)

Behaviour:
- Reset values:
  - core_load=0, core_enable=0, done=0, busy=0, blk_count=0.
  - Pack register=0, word index=0, pack_full=0, state=IDLE, latency counter=0, chain register=0.
  - A partially packed block is discarded.
  - Reset asserted mid-RUN aborts the block with no done pulse.
- Word packing:
  - s_ready = !pack_full (combinational).
  - A word is accepted when s_valid && s_ready. It is written to pack[127-32*idx -: 32], then idx increments.
  - Accepting the word at idx==3 sets pack_full=1 and wraps idx to 0.
  - s_data is ignored when s_ready=0.
  - With s_valid held high, a block is packed in 4 consecutive cycles.
- FSM, states IDLE, LAUNCH, RUN:
  - IDLE:
    - If pack_full=1: core_load <= block (after the chaining XOR when enabled), core_enable <= 1, pack_full <= 0, go to LAUNCH.
    - The word packer is free again from the next cycle. No word is accepted in the launch cycle, since s_ready=0 then.
  - LAUNCH:
    - core_enable <= 0, counter <= 1, go to RUN.
    - core_enable is therefore high for exactly one cycle. core_load holds stable until the next launch.
  - RUN:
    - Counter increments every cycle.
    - When counter==LATENCY-1: done <= 1 for one cycle, blk_count <= blk_count+1, go to IDLE.
  - done rises exactly LATENCY cycles after the cycle in which core_enable was high.
- busy=1 in LAUNCH and RUN, 0 in IDLE.
- Back-to-back operation:
  - If a full block is already pending when done fires, the next launch happens in the cycle after done (IDLE sees pack_full).
  - Steady-state block period is LATENCY+1 cycles.
- Packing continues during RUN. Once pack_full=1, s_ready stays low until that block launches.
- core_out is sampled only on the done cycle, and only with CBC_EN.
- blk_count wraps from 2^CNT_W-1 to 0.

Optional Feature:
- Macro CBC_EN.
- When defined:
  - A 128-bit chain register is added.
  - The launched block is pack ^ chain.
  - On the done cycle, chain <= core_out.
  - iv_load=1 sets chain <= iv in any state. If iv_load coincides with done, iv_load wins.
- When undefined:
  - No chain register; the block is launched unmodified.
  - iv and iv_load are ignored (ports remain, unconnected internally).

Test Plan:
- Reset, then words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF on consecutive cycles -> core_load=0x00112233445566778899AABBCCDDEEFF; core_enable pulses 1 cycle; done exactly 12 cycles later; blk_count=1.
- Eight words streamed continuously -> s_ready low from word 4 until the first launch, low again after word 8 until the second launch; second core_enable exactly 13 cycles after the first; blk_count=2.
- s_valid toggling 1/0 each cycle -> only valid-and-ready words packed; block identical to the contiguous case.
- Reset asserted on RUN counter==5 with 2 words pending -> no done; all outputs zero next cycle; the next 4 words form a fresh block starting at bits [127:96].
- CBC_EN: iv_load with iv=0x000102030405060708090A0B0C0D0E0F, then an all-zero block -> core_load=iv; core_out modelled as 0xA5 repeated; second zero block -> core_load=0xA5 repeated.
- CBC_EN: iv_load asserted on the same cycle as done -> chain register holds iv, not core_out.
